twpm_wb_decoder: RTL and testbench

//  Wishbone address decoder and response arbiter between the NEORV32 external bus master and the TwPM slaves.

---
 rtl/twpm_wb_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_twpm_wb_decoder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twpm_wb_decoder.sv
// Wishbone address decoder and response arbiter between the NEORV32 external
// bus master and the two TwPM slaves (FPGA register/RAM window, DDR3 controller).
// Each request is registered, routed to one slave with a gated strobe, and the
// selected slave's data/ack/err are returned to the master. Unmapped accesses
// and hung slaves become a master error, and the last error is logged.
module twpm_wb_decoder #(
  parameter logic [3:0]  SLV0_TAG       = 4'hF,
  parameter logic [3:0]  SLV1_TAG       = 4'h9,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // master side
  input  logic [31:0] m_adr_i,
  input  logic [31:0] m_dat_i,
  input  logic        m_we_i,
  input  logic [3:0]  m_sel_i,
  input  logic        m_stb_i,
  input  logic        m_cyc_i,
  output logic [31:0] m_dat_o,
  output logic        m_ack_o,
  output logic        m_err_o,
  // shared slave request
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_cyc_o,
  // slave 0
  output logic        s0_stb_o,
  input  logic [31:0] s0_dat_i,
  input  logic        s0_ack_i,
  input  logic        s0_err_i,
  // slave 1
  output logic        s1_stb_o,
  input  logic [31:0] s1_dat_i,
  input  logic        s1_ack_i,
  input  logic        s1_err_i,
  // error log
  output logic [31:0] err_adr_o,
  output logic [1:0]  err_cause_o,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_UNMAPPED = 2'b01,
    CAUSE_SLV_ERR  = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } cause_t;

  // Last counter value seen in BUSY before the timeout fires; BUSY therefore
  // lasts exactly TIMEOUT_CYCLES cycles when the slave stays silent.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        tgt_q, tgt_d;          // 0: slave 0, 1: slave 1
  logic        resp_err_q;            // response kind presented in RESP
  logic [15:0] tmo_cnt_q;
  logic [31:0] m_dat_q;
  logic [31:0] s_adr_q, s_dat_q;
  logic        s_we_q;
  logic [3:0]  s_sel_q;
  logic [31:0] err_adr_q;
  cause_t      err_cause_q;
  logic [7:0]  err_cnt_q;

  logic        req;
  logic [3:0]  tag;
  logic        hit0, hit1;
  logic        sel_ack, sel_err;
  logic [31:0] sel_dat;
  logic        tmo_hit;

  logic        capture_req;
  logic        capture_dat;
  logic        set_err;
  cause_t      err_cause_d;
  logic [31:0] err_adr_d;

  assign req  = m_cyc_i & m_stb_i;
  assign tag  = m_adr_i[31:28];
  assign hit0 = (tag == SLV0_TAG);
  assign hit1 = (tag == SLV1_TAG);

  // Only the selected slave's response is visible to the FSM.
  assign sel_ack = tgt_q ? s1_ack_i : s0_ack_i;
  assign sel_err = tgt_q ? s1_err_i : s0_err_i;
  assign sel_dat = tgt_q ? s1_dat_i : s0_dat_i;
  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  // Next-state and control decode for the request/response FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    tgt_d       = tgt_q;
    capture_req = 1'b0;
    capture_dat = 1'b0;
    set_err     = 1'b0;
    err_cause_d = CAUSE_NONE;
    err_adr_d   = s_adr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          capture_req = 1'b1;
          if (hit0 || hit1) begin
            state_d = ST_BUSY;
            tgt_d   = ~hit0;
          end else begin
            state_d     = ST_RESP;
            set_err     = 1'b1;
            err_cause_d = CAUSE_UNMAPPED;
            err_adr_d   = m_adr_i;
          end
        end
      end

      ST_BUSY: begin
        if (!m_cyc_i) begin
          // master abort: silently abandon the access
          state_d = ST_IDLE;
        end else if (sel_err) begin
          // err has priority over a simultaneous ack
          state_d     = ST_RESP;
          set_err     = 1'b1;
          err_cause_d = CAUSE_SLV_ERR;
        end else if (sel_ack) begin
          state_d     = ST_RESP;
          capture_dat = 1'b1;
        end else if (tmo_hit) begin
          state_d     = ST_RESP;
          set_err     = 1'b1;
          err_cause_d = CAUSE_TIMEOUT;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, request capture, response data, timeout counter and error log.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      tgt_q       <= 1'b0;
      resp_err_q  <= 1'b0;
      tmo_cnt_q   <= '0;
      m_dat_q     <= '0;
      s_adr_q     <= '0;
      s_dat_q     <= '0;
      s_we_q      <= 1'b0;
      s_sel_q     <= '0;
      err_adr_q   <= '0;
      err_cause_q <= CAUSE_NONE;
      err_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      resp_err_q <= set_err;

      if (state_q == ST_BUSY && state_d == ST_BUSY) begin
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
      end else begin
        tmo_cnt_q <= '0;
      end

      if (capture_req) begin
        s_adr_q <= m_adr_i;
        s_dat_q <= m_dat_i;
        s_we_q  <= m_we_i;
        s_sel_q <= m_sel_i;
      end

      if (capture_dat) begin
        m_dat_q <= sel_dat;
      end

      if (set_err) begin
        err_adr_q   <= err_adr_d;
        err_cause_q <= err_cause_d;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
    end
  end

  // Strobes and responses decode straight from registered state, so they all
  // drop on the same edge that leaves BUSY/RESP, including the reset edge.
  assign s_cyc_o     = (state_q == ST_BUSY);
  assign s0_stb_o    = s_cyc_o & ~tgt_q;
  assign s1_stb_o    = s_cyc_o &  tgt_q;
  assign m_ack_o     = (state_q == ST_RESP) & ~resp_err_q;
  assign m_err_o     = (state_q == ST_RESP) &  resp_err_q;
  assign m_dat_o     = m_dat_q;
  assign s_adr_o     = s_adr_q;
  assign s_dat_o     = s_dat_q;
  assign s_we_o      = s_we_q;
  assign s_sel_o     = s_sel_q;
  assign err_adr_o   = err_adr_q;
  assign err_cause_o = err_cause_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_twpm_wb_decoder.sv
// Testbench for twpm_wb_decoder: directed master accesses against two scripted
// slave responders; expected responses go into a queue that a monitor drains
// whenever the decoder presents m_ack_o or m_err_o.
module tb_twpm_wb_decoder;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] m_adr_i, m_dat_i;
  logic        m_we_i;
  logic [3:0]  m_sel_i;
  logic        m_stb_i, m_cyc_i;
  logic [31:0] m_dat_o;
  logic        m_ack_o, m_err_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_we_o;
  logic [3:0]  s_sel_o;
  logic        s_cyc_o;
  logic        s0_stb_o, s0_ack_i, s0_err_i;
  logic [31:0] s0_dat_i;
  logic        s1_stb_o, s1_ack_i, s1_err_i;
  logic [31:0] s1_dat_i;
  logic [31:0] err_adr_o;
  logic [1:0]  err_cause_o;
  logic [7:0]  err_cnt_o;

  twpm_wb_decoder #(
    .SLV0_TAG      (4'hF),
    .SLV1_TAG      (4'h9),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .m_adr_i    (m_adr_i),
    .m_dat_i    (m_dat_i),
    .m_we_i     (m_we_i),
    .m_sel_i    (m_sel_i),
    .m_stb_i    (m_stb_i),
    .m_cyc_i    (m_cyc_i),
    .m_dat_o    (m_dat_o),
    .m_ack_o    (m_ack_o),
    .m_err_o    (m_err_o),
    .s_adr_o    (s_adr_o),
    .s_dat_o    (s_dat_o),
    .s_we_o     (s_we_o),
    .s_sel_o    (s_sel_o),
    .s_cyc_o    (s_cyc_o),
    .s0_stb_o   (s0_stb_o),
    .s0_dat_i   (s0_dat_i),
    .s0_ack_i   (s0_ack_i),
    .s0_err_i   (s0_err_i),
    .s1_stb_o   (s1_stb_o),
    .s1_dat_i   (s1_dat_i),
    .s1_ack_i   (s1_ack_i),
    .s1_err_i   (s1_err_i),
    .err_adr_o  (err_adr_o),
    .err_cause_o(err_cause_o),
    .err_cnt_o  (err_cnt_o)
  );

  typedef enum int {M_ACK, M_ERR, M_BOTH, M_NEVER} slv_mode_t;

  typedef struct {
    logic        is_err;
    logic [31:0] dat;
    logic [1:0]  cause;
    logic [31:0] adr;
  } exp_t;

  exp_t        exp_q[$];
  int          total;
  int          bad;
  int          cyc_cnt;

  // slave responder configuration (written by the main sequence only)
  slv_mode_t   s_mode  [2];
  int          s_delay [2];
  logic [31:0] s_rdata [2];

  // request currently on the bus, for the hold check
  logic [31:0] cur_adr, cur_dat;
  logic        cur_we;
  logic [3:0]  cur_sel;

  // monitor statistics (written by the monitor only)
  int          s0_hi;
  int          s1_hi;
  int          hold_bad;

  // per-access results from do_req
  int          last_s0;
  int          last_s1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    cyc_cnt = 0;
    forever begin
      @(posedge clk_i);
      cyc_cnt++;
    end
  end

  // Slave 0 responder: after s_delay cycles of strobe, drive the configured response.
  initial begin : slv0_resp
    int w;
    w = 0;
    s0_ack_i = 1'b0;
    s0_err_i = 1'b0;
    s0_dat_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      s0_ack_i = 1'b0;
      s0_err_i = 1'b0;
      if (s0_stb_o) begin
        if (w == s_delay[0] && s_mode[0] != M_NEVER) begin
          s0_ack_i = (s_mode[0] == M_ACK) || (s_mode[0] == M_BOTH);
          s0_err_i = (s_mode[0] == M_ERR) || (s_mode[0] == M_BOTH);
          s0_dat_i = s_rdata[0];
          w = 0;
        end else begin
          w++;
        end
      end else begin
        w = 0;
      end
    end
  end

  // Slave 1 responder, same behaviour as slave 0.
  initial begin : slv1_resp
    int w;
    w = 0;
    s1_ack_i = 1'b0;
    s1_err_i = 1'b0;
    s1_dat_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      s1_ack_i = 1'b0;
      s1_err_i = 1'b0;
      if (s1_stb_o) begin
        if (w == s_delay[1] && s_mode[1] != M_NEVER) begin
          s1_ack_i = (s_mode[1] == M_ACK) || (s_mode[1] == M_BOTH);
          s1_err_i = (s_mode[1] == M_ERR) || (s_mode[1] == M_BOTH);
          s1_dat_i = s_rdata[1];
          w = 0;
        end else begin
          w++;
        end
      end else begin
        w = 0;
      end
    end
  end

  // Monitor: sample on the falling edge, pop and compare on every response.
  initial begin : monitor
    exp_t e;
    s0_hi    = 0;
    s1_hi    = 0;
    hold_bad = 0;
    forever begin
      @(negedge clk_i);
      if (s0_stb_o) s0_hi++;
      if (s1_stb_o) s1_hi++;
      if (s_cyc_o && (s_adr_o !== cur_adr || s_dat_o !== cur_dat ||
                      s_we_o !== cur_we || s_sel_o !== cur_sel)) begin
        hold_bad++;
      end
      if (m_ack_o || m_err_o) begin
        check("ack_err_exclusive", {31'b0, m_ack_o & m_err_o}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {30'b0, m_ack_o, m_err_o}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_err", {31'b0, m_err_o}, {31'b0, e.is_err});
          check("resp_ack", {31'b0, m_ack_o}, {31'b0, ~e.is_err});
          if (!e.is_err) begin
            check("resp_dat", m_dat_o, e.dat);
          end else begin
            check("resp_cause", {30'b0, err_cause_o}, {30'b0, e.cause});
            check("resp_err_adr", err_adr_o, e.adr);
          end
        end
      end
    end
  end

  // One complete master access; exp_lat is the number of clock edges from the
  // request being presented to the response being visible (-1: not checked).
  task automatic do_req(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                        input logic [3:0] sel, input logic exp_err, input logic [31:0] exp_dat,
                        input logic [1:0] exp_cause, input int exp_lat, input string tag);
    exp_t e;
    int   n, s0b, s1b, hb;
    e.is_err = exp_err;
    e.dat    = exp_dat;
    e.cause  = exp_cause;
    e.adr    = adr;
    exp_q.push_back(e);
    cur_adr = adr;
    cur_dat = dat;
    cur_we  = we;
    cur_sel = sel;
    s0b = s0_hi;
    s1b = s1_hi;
    hb  = hold_bad;
    m_adr_i = adr;
    m_dat_i = dat;
    m_we_i  = we;
    m_sel_i = sel;
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk_i);
      #1;
      n++;
    end while (!(m_ack_o || m_err_o) && n < 400);
    if (!(m_ack_o || m_err_o)) begin
      check({tag, "_no_response"}, {31'b0, m_ack_o | m_err_o}, 32'd1);
    end
    if (exp_lat >= 0) check({tag, "_latency"}, n, exp_lat);
    @(posedge clk_i);
    #1;
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    last_s0 = s0_hi - s0b;
    last_s1 = s1_hi - s1b;
    check({tag, "_req_hold"}, hold_bad - hb, 32'd0);
  endtask

  // Present a request without waiting for a response (abort / reset cases).
  task automatic start_req(input logic [31:0] adr);
    cur_adr = adr;
    cur_dat = 32'h0BAD_F00D;
    cur_we  = 1'b0;
    cur_sel = 4'hF;
    m_adr_i = adr;
    m_dat_i = 32'h0BAD_F00D;
    m_we_i  = 1'b0;
    m_sel_i = 4'hF;
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
  endtask

  initial begin : main
    total   = 0;
    bad     = 0;
    rst_i   = 1'b1;
    m_adr_i = '0;
    m_dat_i = '0;
    m_we_i  = 1'b0;
    m_sel_i = '0;
    m_stb_i = 1'b0;
    m_cyc_i = 1'b0;
    cur_adr = '0;
    cur_dat = '0;
    cur_we  = 1'b0;
    cur_sel = '0;
    last_s0 = 0;
    last_s1 = 0;
    s_mode[0] = M_ACK;  s_delay[0] = 0; s_rdata[0] = '0;
    s_mode[1] = M_ACK;  s_delay[1] = 0; s_rdata[1] = '0;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_m_ack",    {31'b0, m_ack_o},  32'd0);
    check("rst_m_err",    {31'b0, m_err_o},  32'd0);
    check("rst_s_cyc",    {31'b0, s_cyc_o},  32'd0);
    check("rst_stbs",     {30'b0, s0_stb_o, s1_stb_o}, 32'd0);
    check("rst_err_cnt",  {24'b0, err_cnt_o},   32'd0);
    check("rst_err_cause",{30'b0, err_cause_o}, 32'd0);
    check("rst_err_adr",  err_adr_o, 32'd0);
    check("rst_m_dat",    m_dat_o,   32'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // 1: read slave 0, ack in first BUSY cycle
    s_mode[0] = M_ACK; s_delay[0] = 0; s_rdata[0] = 32'h0000_0005;
    do_req(32'hF000_0000, 32'h0, 1'b0, 4'hF, 1'b0, 32'h0000_0005, 2'b00, 2, "t1");
    check("t1_s0_stb_cycles", last_s0, 32'd1);
    check("t1_s1_stb_cycles", last_s1, 32'd0);

    // 2: write slave 1, ack after 10 cycles of strobe
    s_mode[1] = M_ACK; s_delay[1] = 10; s_rdata[1] = 32'h1234_5678;
    do_req(32'h9000_1000, 32'hDEAD_BEEF, 1'b1, 4'hF, 1'b0, 32'h1234_5678, 2'b00, 12, "t2");
    check("t2_s1_stb_cycles", last_s1, 32'd11);
    check("t2_s0_stb_cycles", last_s0, 32'd0);
    check("t2_err_cnt", {24'b0, err_cnt_o}, 32'd0);

    // 3: unmapped read
    do_req(32'h4000_0000, 32'h0, 1'b0, 4'hF, 1'b1, 32'h0, 2'b01, 1, "t3");
    check("t3_stb_cycles", last_s0 + last_s1, 32'd0);
    check("t3_err_cause", {30'b0, err_cause_o}, 32'd1);
    check("t3_err_adr", err_adr_o, 32'h4000_0000);
    check("t3_err_cnt", {24'b0, err_cnt_o}, 32'd1);

    // 4: slave 0 never answers -> timeout after 255 strobe cycles
    s_mode[0] = M_NEVER;
    do_req(32'hF000_0010, 32'h0, 1'b0, 4'h3, 1'b1, 32'h0, 2'b11, 256, "t4");
    check("t4_s0_stb_cycles", last_s0, 32'd255);
    check("t4_err_cause", {30'b0, err_cause_o}, 32'd3);
    check("t4_err_cnt", {24'b0, err_cnt_o}, 32'd2);

    // 5a: slave 1 raises ack and err together -> err wins
    s_mode[1] = M_BOTH; s_delay[1] = 2; s_rdata[1] = 32'hCAFE_0001;
    do_req(32'h9000_0020, 32'h5555_AAAA, 1'b1, 4'hC, 1'b1, 32'h0, 2'b10, 4, "t5a");
    check("t5a_err_cnt", {24'b0, err_cnt_o}, 32'd3);
    check("t5a_m_dat_kept", m_dat_o, 32'h1234_5678);

    // 5b: master abort in BUSY -> back to IDLE, no response, nothing logged
    s_mode[0] = M_NEVER;
    start_req(32'hF000_0030);
    repeat (3) @(posedge clk_i);
    #1;
    check("t5b_stb_before_abort", {31'b0, s0_stb_o}, 32'd1);
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("t5b_stb_after_abort", {30'b0, s0_stb_o, s_cyc_o}, 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    check("t5b_err_cnt", {24'b0, err_cnt_o}, 32'd3);
    check("t5b_err_cause", {30'b0, err_cause_o}, 32'd2);

    // decoder accepts a normal access after the abort
    s_mode[0] = M_ACK; s_delay[0] = 1; s_rdata[0] = 32'hA5A5_0001;
    do_req(32'hF000_0040, 32'h0, 1'b0, 4'h1, 1'b0, 32'hA5A5_0001, 2'b00, 3, "t5c");

    // 6a: 300 unmapped accesses saturate the error counter
    for (int i = 0; i < 300; i++) begin
      do_req(32'h0000_0100 + 32'(i * 4), 32'h0, 1'b0, 4'hF, 1'b1, 32'h0, 2'b01, 1, "t6");
    end
    check("t6_err_cnt_sat", {24'b0, err_cnt_o}, 32'h0000_00FF);
    check("t6_err_adr", err_adr_o, 32'h0000_0100 + 32'(299 * 4));

    // 6b: reset in the middle of a BUSY access
    s_mode[1] = M_NEVER;
    start_req(32'h9000_0050);
    repeat (5) @(posedge clk_i);
    #1;
    check("t6b_busy_before_rst", {31'b0, s1_stb_o}, 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("t6b_rst_stbs", {29'b0, s0_stb_o, s1_stb_o, s_cyc_o}, 32'd0);
    check("t6b_rst_resp", {30'b0, m_ack_o, m_err_o}, 32'd0);
    check("t6b_rst_err_cnt", {24'b0, err_cnt_o}, 32'd0);
    check("t6b_rst_err_cause", {30'b0, err_cause_o}, 32'd0);
    check("t6b_rst_err_adr", err_adr_o, 32'd0);
    check("t6b_rst_m_dat", m_dat_o, 32'd0);
    check("t6b_rst_s_adr", s_adr_o, 32'd0);
    check("t6b_rst_s_dat", s_dat_o, 32'd0);
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;

    // working again after reset
    s_mode[1] = M_ACK; s_delay[1] = 0; s_rdata[1] = 32'h7777_0002;
    do_req(32'h9000_0060, 32'h0, 1'b0, 4'hF, 1'b0, 32'h7777_0002, 2'b00, 2, "t7");

    repeat (2) @(posedge clk_i);
    check("exp_queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
